writeback_unit: RTL and testbench

- Parametrised successor to the single-cycle writeback stage: final pipeline stage of the BatPU2 core.
- Buffers one instruction's result and selects one of four sources: ALU, memory, immediate, link.
- Stalls on late memory data, with a bounded wait timeout.
- Drives register-file write and forwarding buses, and latches a sticky halt.

---
 rtl/writeback_pkg.sv | 35 +++
 rtl/wb_mem_wait_timer.sv | 40 ++++
 rtl/writeback_unit.sv | 162 ++++++++++++++++
 tb/tb_writeback_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared types for the BatPU2 writeback stage: control word layout, source/destination
// selectors and FSM state encoding.
package writeback_pkg;

    localparam int WB_CTRL_W = 6;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_IMM  = 2'd2,
        SRC_LINK = 2'd3
    } wb_src_e;

    typedef enum logic [1:0] {
        DST_A    = 2'd0,
        DST_B    = 2'd1,
        DST_C    = 2'd2,
        DST_NONE = 2'd3
    } wb_dst_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_HALTED   = 2'd2
    } wb_state_e;

    // Packed MSB first, so 'we' lands on bit 0 and 'halt' on bit 5.
    typedef struct packed {
        logic    halt;
        wb_src_e src;
        wb_dst_e dst;
        logic    we;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_mem_wait_timer.sv
// Counts clk_en edges spent stalled on load data and flags the cycle the wait limit is reached.
// MEM_TIMEOUT = 0 disables the limit (wait forever).
module wb_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic clk_en,
    input  logic wait_req,
    output logic timeout_hit
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wait_cnt <= '0;
        end else if (clk_en) begin
            if (wait_req && !timeout_hit) begin
                // Saturate so the unlimited configuration cannot wrap.
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = wait_req && (wait_cnt == CNT_W'(MEM_TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/writeback_unit.sv
// BatPU2 writeback stage: buffers one result, selects ALU/MEM/IMM/LINK, stalls on late loads
// with a bounded wait, drives the register-file write and forwarding buses, latches a sticky halt.
// Optional WB_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
//
// state       | meaning
// ------------+---------------------------------------------------
// ST_RUN      | normal flow, stage advances on clk_en
// ST_WAIT_MEM | load in stage, waiting on mem_valid or the timeout
// ST_HALTED   | halt committed; stage frozen, writes blocked
module writeback_unit
    import writeback_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int INST_W      = 16,
    parameter int REG_AW      = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int R0_WIRED    = 1
) (
    input  logic                 clk,
    input  logic                 sync_rst,
    input  logic                 clk_en,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    from_alu,
    input  logic [DATA_W-1:0]    from_memory,
    input  logic                 mem_valid,
    input  logic [DATA_W-1:0]    link_in,
    input  logic [INST_W-1:0]    inst_bus,
    input  logic [WB_CTRL_W-1:0] ctr_word_in,
    output logic [REG_AW-1:0]    rd_addr,
    output logic [DATA_W-1:0]    to_reg,
    output logic                 reg_we,
    output logic                 wb_stall,
    output logic                 clk_hlt,
    output logic                 mem_err,
    output logic                 fwd_prev_valid,
    output logic [REG_AW-1:0]    fwd_prev_addr,
    output logic [DATA_W-1:0]    fwd_prev_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [15:0]          retire_cnt
`endif
);

    logic              valid_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] link_q;
    logic [INST_W-1:0] inst_q;
    wb_ctrl_t          ctrl_q;

    wb_state_e state_q;
    wb_state_e state_d;

    logic wait_req;
    logic timeout_hit;
    logic commit;
    logic advance;
    logic unused_inst_hi;

    assign unused_inst_hi = ^inst_q[INST_W-1 -: 4];

    assign wait_req = valid_q && (ctrl_q.src == SRC_MEM) && !mem_valid && (state_q != ST_HALTED);
    assign wb_stall = wait_req && !timeout_hit;
    assign commit   = valid_q && !wb_stall && (state_q != ST_HALTED);
    assign advance  = clk_en && !wb_stall && (state_q != ST_HALTED);
    assign clk_hlt  = (state_q == ST_HALTED);

    wb_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .clk_en     (clk_en),
        .wait_req   (wait_req),
        .timeout_hit(timeout_hit)
    );

    always_comb begin
        rd_addr = '0;
        to_reg  = '0;
        case (ctrl_q.dst)
            DST_A:   rd_addr = inst_q[INST_W-5 -: REG_AW];
            DST_B:   rd_addr = inst_q[INST_W-5-REG_AW -: REG_AW];
            DST_C:   rd_addr = inst_q[INST_W-5-2*REG_AW -: REG_AW];
            default: rd_addr = '0;
        endcase
        // Load data is taken live from the memory port, not from the stage.
        case (ctrl_q.src)
            SRC_ALU:  to_reg = alu_q;
            SRC_MEM:  to_reg = from_memory;
            SRC_IMM:  to_reg = inst_q[DATA_W-1:0];
            default:  to_reg = link_q;
        endcase
        reg_we = commit && ctrl_q.we && (ctrl_q.dst != DST_NONE)
                 && !((R0_WIRED != 0) && (rd_addr == '0)) && !timeout_hit;
    end

    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            case (state_q)
                ST_RUN, ST_WAIT_MEM: begin
                    if (commit && ctrl_q.halt) begin
                        state_d = ST_HALTED;
                    end else if (wb_stall) begin
                        state_d = ST_WAIT_MEM;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q        <= ST_RUN;
            valid_q        <= 1'b0;
            alu_q          <= '0;
            link_q         <= '0;
            inst_q         <= '0;
            ctrl_q         <= '0;
            mem_err        <= 1'b0;
            fwd_prev_valid <= 1'b0;
            fwd_prev_addr  <= '0;
            fwd_prev_data  <= '0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                valid_q <= in_valid;
                alu_q   <= from_alu;
                link_q  <= link_in;
                inst_q  <= inst_bus;
                ctrl_q  <= wb_ctrl_t'(ctr_word_in);
            end
            if (clk_en) begin
                if (timeout_hit && commit) begin
                    mem_err <= 1'b1;
                end
                if (reg_we) begin
                    fwd_prev_valid <= 1'b1;
                    fwd_prev_addr  <= rd_addr;
                    fwd_prev_data  <= to_reg;
                end else begin
                    fwd_prev_valid <= 1'b0;
                end
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            retire_cnt <= '0;
        end else if (clk_en && commit) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: two instances share stimulus, one with r0 suppression
// and one without, both with a 4-cycle memory wait limit.
module tb_writeback_unit;

    localparam int DATA_W = 8;
    localparam int INST_W = 16;
    localparam int REG_AW = 4;

    logic              clk;
    logic              sync_rst;
    logic              clk_en;
    logic              in_valid;
    logic [DATA_W-1:0] from_alu;
    logic [DATA_W-1:0] from_memory;
    logic              mem_valid;
    logic [DATA_W-1:0] link_in;
    logic [INST_W-1:0] inst_bus;
    logic [5:0]        ctr_word_in;

    logic [REG_AW-1:0] rd_addr, rd_addr2;
    logic [DATA_W-1:0] to_reg, to_reg2;
    logic              reg_we, reg_we2;
    logic              wb_stall, wb_stall2;
    logic              clk_hlt, clk_hlt2;
    logic              mem_err, mem_err2;
    logic              fwd_prev_valid, fwd_prev_valid2;
    logic [REG_AW-1:0] fwd_prev_addr, fwd_prev_addr2;
    logic [DATA_W-1:0] fwd_prev_data, fwd_prev_data2;
`ifdef WB_RETIRE_CNT_EN
    logic [15:0]       retire_cnt, retire_cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    writeback_unit #(
        .DATA_W(DATA_W), .INST_W(INST_W), .REG_AW(REG_AW), .MEM_TIMEOUT(4), .R0_WIRED(1)
    ) dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .in_valid(in_valid),
        .from_alu(from_alu), .from_memory(from_memory), .mem_valid(mem_valid),
        .link_in(link_in), .inst_bus(inst_bus), .ctr_word_in(ctr_word_in),
        .rd_addr(rd_addr), .to_reg(to_reg), .reg_we(reg_we), .wb_stall(wb_stall),
        .clk_hlt(clk_hlt), .mem_err(mem_err), .fwd_prev_valid(fwd_prev_valid),
        .fwd_prev_addr(fwd_prev_addr), .fwd_prev_data(fwd_prev_data)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    writeback_unit #(
        .DATA_W(DATA_W), .INST_W(INST_W), .REG_AW(REG_AW), .MEM_TIMEOUT(4), .R0_WIRED(0)
    ) dut_r0 (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .in_valid(in_valid),
        .from_alu(from_alu), .from_memory(from_memory), .mem_valid(mem_valid),
        .link_in(link_in), .inst_bus(inst_bus), .ctr_word_in(ctr_word_in),
        .rd_addr(rd_addr2), .to_reg(to_reg2), .reg_we(reg_we2), .wb_stall(wb_stall2),
        .clk_hlt(clk_hlt2), .mem_err(mem_err2), .fwd_prev_valid(fwd_prev_valid2),
        .fwd_prev_addr(fwd_prev_addr2), .fwd_prev_data(fwd_prev_data2)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] mk_ctrl(input logic we, input logic [1:0] dst,
                                           input logic [1:0] src, input logic halt);
        return {halt, src, dst, we};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [5:0] c, input logic [15:0] ins,
                         input logic [7:0] alu, input logic [7:0] lnk);
        in_valid    = v;
        ctr_word_in = c;
        inst_bus    = ins;
        from_alu    = alu;
        link_in     = lnk;
        #1;
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
    endtask

    initial begin
        sync_rst = 1'b1; clk_en = 1'b1; mem_valid = 1'b0; from_memory = '0;
        in_valid = 1'b0; ctr_word_in = '0; inst_bus = '0; from_alu = '0; link_in = '0;
        tick();
        tick();
        sync_rst = 1'b0;
        #1;
        check_val("rst_rd_addr", rd_addr, 0);
        check_val("rst_to_reg", to_reg, 0);
        check_val("rst_reg_we", reg_we, 0);
        check_val("rst_stall", wb_stall, 0);
        check_val("rst_hlt", clk_hlt, 0);
        check_val("rst_mem_err", mem_err, 0);
        check_val("rst_fwd", {fwd_prev_valid, fwd_prev_addr, fwd_prev_data}, 0);

        // ALU write to A=3, with a clk_en-low hold cycle before commit
        drive(1'b1, mk_ctrl(1, 2'd0, 2'd0, 0), 16'h0300, 8'h5A, 8'h00);
        tick();
        drive(1'b0, 6'd0, 16'h0000, 8'h00, 8'h00);
        clk_en = 1'b0;
        check_val("alu_rd_addr", rd_addr, 3);
        check_val("alu_to_reg", to_reg, 8'h5A);
        check_val("alu_reg_we", reg_we, 1);
        tick();
        check_val("hold_reg_we", reg_we, 1);
        check_val("hold_to_reg", to_reg, 8'h5A);
        check_val("hold_fwd_valid", fwd_prev_valid, 0);
        clk_en = 1'b1;
        tick();
        check_val("alu_fwd", {fwd_prev_valid, fwd_prev_addr, fwd_prev_data}, {1'b1, 4'd3, 8'h5A});
        check_val("alu_bubble_we", reg_we, 0);
        tick();
        check_val("alu_fwd_clear", fwd_prev_valid, 0);

        // Late load to B=4: three stalled cycles, data on the fourth
        drive(1'b1, mk_ctrl(1, 2'd1, 2'd1, 0), 16'h0040, 8'h00, 8'h00);
        from_memory = 8'hEE;
        tick();
        drive(1'b0, 6'd0, 16'h0000, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("load_stall%0d", i), {wb_stall, reg_we}, 2'b10);
            tick();
        end
        mem_valid = 1'b1; from_memory = 8'hC3;
        #1;
        check_val("load_stall_drop", wb_stall, 0);
        check_val("load_write", {reg_we, rd_addr, to_reg}, {1'b1, 4'd4, 8'hC3});
        tick();
        mem_valid = 1'b0;
        #1;
        check_val("load_fwd", {fwd_prev_valid, fwd_prev_addr, fwd_prev_data}, {1'b1, 4'd4, 8'hC3});
        check_val("load_advanced", {wb_stall, reg_we}, 2'b00);

        // Immediate write to C=0: suppressed only where r0 is wired
        drive(1'b1, mk_ctrl(1, 2'd2, 2'd2, 0), 16'h1230, 8'h00, 8'h00);
        tick();
        drive(1'b1, mk_ctrl(1, 2'd3, 2'd0, 0), 16'h0F00, 8'h99, 8'h00);
        check_val("r0_wired_we", reg_we, 0);
        check_val("r0_free_write", {reg_we2, rd_addr2, to_reg2}, {1'b1, 4'd0, 8'h30});
        tick();
        drive(1'b0, 6'd0, 16'h0000, 8'h00, 8'h00);
        check_val("dst_none_we", reg_we2, 0);
        check_val("dst_none_addr", rd_addr2, 0);
        tick();

        // Reset while stalled, then a full timeout from a cleared counter
        drive(1'b1, mk_ctrl(1, 2'd0, 2'd1, 0), 16'h0200, 8'h00, 8'h00);
        tick();
        drive(1'b0, 6'd0, 16'h0000, 8'h00, 8'h00);
        check_val("midrst_stall", wb_stall, 1);
        tick();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        #1;
        check_val("midrst_clear", {wb_stall, reg_we, fwd_prev_valid}, 3'b000);
        drive(1'b1, mk_ctrl(1, 2'd0, 2'd1, 0), 16'h0500, 8'h00, 8'h00);
        tick();
        drive(1'b1, mk_ctrl(1, 2'd0, 2'd0, 0), 16'h0700, 8'h11, 8'h00);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("to_stall%0d", i), {wb_stall, reg_we}, 2'b10);
            tick();
        end
        check_val("to_hit", {wb_stall, reg_we, mem_err}, 3'b000);
        tick();
        drive(1'b0, 6'd0, 16'h0000, 8'h00, 8'h00);
        check_val("to_mem_err", mem_err, 1);
        check_val("to_next", {reg_we, rd_addr, to_reg}, {1'b1, 4'd7, 8'h11});
        check_val("to_no_fwd", fwd_prev_valid, 0);
        tick();
        check_val("to_sticky", mem_err, 1);
        do_reset();
        #1;
        check_val("to_rst_clear", mem_err, 0);

        // Halt on a link write: one write, then frozen
        drive(1'b1, mk_ctrl(1, 2'd0, 2'd3, 1), 16'h0900, 8'h00, 8'h21);
        tick();
        drive(1'b1, mk_ctrl(1, 2'd0, 2'd0, 0), 16'h0A00, 8'h77, 8'h00);
        check_val("halt_write", {reg_we, rd_addr, to_reg}, {1'b1, 4'd9, 8'h21});
        check_val("halt_pre_hlt", clk_hlt, 0);
        tick();
        check_val("halt_hlt", {clk_hlt, reg_we}, 2'b10);
        check_val("halt_fwd", {fwd_prev_valid, fwd_prev_addr, fwd_prev_data}, {1'b1, 4'd9, 8'h21});
        tick();
        tick();
        check_val("halt_frozen", {clk_hlt, reg_we, fwd_prev_valid}, 3'b100);
        do_reset();
        drive(1'b0, 6'd0, 16'h0000, 8'h00, 8'h00);
        check_val("halt_rst", clk_hlt, 0);

        // Load and halt on the same instruction with data already valid
        drive(1'b1, mk_ctrl(1, 2'd1, 2'd1, 1), 16'h00F0, 8'h00, 8'h00);
        mem_valid = 1'b1; from_memory = 8'h3C;
        tick();
        drive(1'b0, 6'd0, 16'h0000, 8'h00, 8'h00);
        check_val("memhalt_write", {reg_we, rd_addr, to_reg}, {1'b1, 4'd15, 8'h3C});
        tick();
        mem_valid = 1'b0;
        #1;
        check_val("memhalt_hlt", {clk_hlt, reg_we}, 2'b10);
        check_val("memhalt_fwd", fwd_prev_data, 8'h3C);
        do_reset();

`ifdef WB_RETIRE_CNT_EN
        #1;
        check_val("ret_rst", retire_cnt, 0);
        for (int i = 0; i < 7; i++) begin
            drive((i != 2) && (i != 4), mk_ctrl(1, 2'd0, 2'd0, 0), 16'h0100, 8'h01, 8'h00);
            tick();
        end
        drive(1'b0, 6'd0, 16'h0000, 8'h00, 8'h00);
        tick();
        check_val("ret_count", retire_cnt, 5);
        clk_en = 1'b0;
        drive(1'b1, mk_ctrl(1, 2'd0, 2'd0, 0), 16'h0100, 8'h01, 8'h00);
        tick();
        tick();
        check_val("ret_hold", retire_cnt, 5);
        clk_en = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
